// File: rtl/video_pkg.sv
// Shared encodings for the video pattern generator: pattern selects, link modes,
// the timing FSM state type and the colour-bar palette.
package video_pkg;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GRAD  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_SOLID = 2'd3
  } pattern_t;

  localparam logic LINK_SINGLE = 1'b0;
  localparam logic LINK_DUAL   = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t RGB_WHITE   = 24'hFFFFFF;
  localparam rgb_t RGB_YELLOW  = 24'hFFFF00;
  localparam rgb_t RGB_CYAN    = 24'h00FFFF;
  localparam rgb_t RGB_GREEN   = 24'h00FF00;
  localparam rgb_t RGB_MAGENTA = 24'hFF00FF;
  localparam rgb_t RGB_RED     = 24'hFF0000;
  localparam rgb_t RGB_BLUE    = 24'h0000FF;
  localparam rgb_t RGB_BLACK   = 24'h000000;

  // Bars run left to right in descending luminance order.
  function automatic rgb_t bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return RGB_WHITE;
      3'd1:    return RGB_YELLOW;
      3'd2:    return RGB_CYAN;
      3'd3:    return RGB_GREEN;
      3'd4:    return RGB_MAGENTA;
      3'd5:    return RGB_RED;
      3'd6:    return RGB_BLUE;
      default: return RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/video_pattern_gen_if.sv
// Parallel RGB888 pixel bus (sync, data valid, two pixel lanes) shared with the capture monitor.
interface video_pattern_gen_if;
  logic       vs;
  logic       hs;
  logic       de;
  logic [7:0] data0_r, data0_g, data0_b;
  logic [7:0] data1_r, data1_g, data1_b;

  modport master (output vs, hs, de, data0_r, data0_g, data0_b, data1_r, data1_g, data1_b);
  modport slave  (input  vs, hs, de, data0_r, data0_g, data0_b, data1_r, data1_g, data1_b);
endinterface

// File: rtl/video_timing_core.sv
// Raster timing: h/v counters, IDLE/RUN frame gating, registered syncs, sof and frame count.
// An IDLE cycle that sees en_i high doubles as counter cycle (0,0) of the new frame.
module video_timing_core
  import video_pkg::*;
#(
  parameter int   H_ACTIVE = 1536,
  parameter int   H_FP     = 24,
  parameter int   H_SYNC   = 40,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 768,
  parameter int   V_FP     = 3,
  parameter int   V_SYNC   = 6,
  parameter int   V_BP     = 29,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic        pclk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        link_i,
  output logic        hs_o,
  output logic        vs_o,
  output logic        de_o,
  output logic        sof_o,
  output logic [15:0] frame_cnt_o,
  output logic        frame_start,
  output logic        pix_valid,
  output logic [15:0] pix_col,
  output logic [7:0]  pix_row,
  output logic        link_q
);

  localparam logic [15:0] H_SYNC_END    = 16'(H_SYNC);
  localparam logic [15:0] H_DE_START    = 16'(H_SYNC + H_BP);
  localparam logic [15:0] H_ACT_SINGLE  = 16'(H_ACTIVE);
  localparam logic [15:0] H_ACT_DUAL    = 16'(H_ACTIVE / 2);
  localparam logic [15:0] H_LAST_SINGLE = 16'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
  localparam logic [15:0] H_LAST_DUAL   = 16'(H_SYNC + H_BP + H_ACTIVE / 2 + H_FP - 1);
  localparam logic [15:0] V_SYNC_END    = 16'(V_SYNC);
  localparam logic [15:0] V_DE_START    = 16'(V_SYNC + V_BP);
  localparam logic [15:0] V_DE_END      = 16'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [15:0] V_LAST        = 16'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);

  state_t      state, state_nxt;
  logic [15:0] hcnt, vcnt, hcnt_nxt, vcnt_nxt, h_act;
  logic        run, h_last, v_last, f_last, hs_c, vs_c, de_c;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_nxt   = state;
    run         = (state == ST_RUN) || en_i;
    h_act       = (link_q == LINK_DUAL) ? H_ACT_DUAL : H_ACT_SINGLE;
    h_last      = hcnt == ((link_q == LINK_DUAL) ? H_LAST_DUAL : H_LAST_SINGLE);
    v_last      = vcnt == V_LAST;
    f_last      = run && h_last && v_last;
    frame_start = run && (hcnt == '0) && (vcnt == '0);
    hs_c        = run && (hcnt < H_SYNC_END);
    vs_c        = run && (vcnt < V_SYNC_END);
    de_c        = run && (hcnt >= H_DE_START) && (hcnt < H_DE_START + h_act)
                      && (vcnt >= V_DE_START) && (vcnt < V_DE_END);
    pix_valid   = de_c;
    pix_col     = hcnt - H_DE_START;
    pix_row     = 8'(vcnt - V_DE_START);

    case (state)
      ST_IDLE: if (en_i) state_nxt = ST_RUN;
      ST_RUN:  if (f_last && !en_i) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    hcnt_nxt = '0;
    vcnt_nxt = '0;
    if (run && !h_last) begin
      hcnt_nxt = hcnt + 16'd1;
      vcnt_nxt = vcnt;
    end else if (run && !v_last) begin
      vcnt_nxt = vcnt + 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i) begin
      hcnt        <= '0;
      vcnt        <= '0;
      link_q      <= LINK_SINGLE;
      hs_o        <= ~HS_POL;
      vs_o        <= ~VS_POL;
      de_o        <= 1'b0;
      sof_o       <= 1'b0;
      frame_cnt_o <= '0;
    end else begin
      hcnt  <= hcnt_nxt;
      vcnt  <= vcnt_nxt;
      hs_o  <= hs_c ? HS_POL : ~HS_POL;
      vs_o  <= vs_c ? VS_POL : ~VS_POL;
      de_o  <= de_c;
      sof_o <= frame_start;
      if (frame_start) link_q <= link_i;
      if (f_last)      frame_cnt_o <= frame_cnt_o + 16'd1;
    end
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Video test-pattern source: timing core plus a registered pattern mux for one or two pixels per clock.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int   H_ACTIVE = 1536,
  parameter int   H_FP     = 24,
  parameter int   H_SYNC   = 40,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 768,
  parameter int   V_FP     = 3,
  parameter int   V_SYNC   = 6,
  parameter int   V_BP     = 29,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic                       pclk_i,
  input  logic                       rst_i,
  input  logic                       en_i,
  input  logic                       link_i,
  input  logic [1:0]                 pattern_sel_i,
  video_pattern_gen_if.master        pix,
  output logic                       sof_o,
  output logic [15:0]                frame_cnt_o
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic        hs, vs, de, frame_start, pix_valid, link_q;
  logic [15:0] pix_col, x0, x1;
  logic [7:0]  pix_row;
  pattern_t    pat_q;
  rgb_t        px0, px1, d0, d1;

  video_timing_core #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) u_core (
    .pclk_i(pclk_i), .rst_i(rst_i), .en_i(en_i), .link_i(link_i),
    .hs_o(hs), .vs_o(vs), .de_o(de), .sof_o(sof_o), .frame_cnt_o(frame_cnt_o),
    .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_col(pix_col), .pix_row(pix_row), .link_q(link_q)
  );

  // Bar index by threshold compares against constant multiples of the bar width.
  function automatic rgb_t pattern_pixel(input pattern_t pat, input logic [15:0] x,
                                         input logic [7:0] y, input logic [7:0] level);
    logic [2:0] bar;
    bar = '0;
    for (int i = 1; i < 8; i++)
      if (x >= 16'(i * BAR_W)) bar = 3'(i);
    case (pat)
      PAT_BARS:  return bar_colour(bar);
      PAT_GRAD:  return '{r: x[7:0], g: y, b: x[7:0] ^ y};
      PAT_CHECK: return (x[4] ^ y[4]) ? RGB_WHITE : RGB_BLACK;
      default:   return '{r: level, g: level, b: level};
    endcase
  endfunction

  always_comb begin
    x0  = (link_q == LINK_DUAL) ? {pix_col[14:0], 1'b0} : pix_col;
    x1  = {pix_col[14:0], 1'b1};
    px0 = pattern_pixel(pat_q, x0, pix_row, frame_cnt_o[7:0]);
    px1 = pattern_pixel(pat_q, x1, pix_row, frame_cnt_o[7:0]);
  end

  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i) begin
      pat_q <= PAT_BARS;
      d0    <= RGB_BLACK;
      d1    <= RGB_BLACK;
    end else begin
      if (frame_start) pat_q <= pattern_t'(pattern_sel_i);
      d0 <= pix_valid ? px0 : RGB_BLACK;
      d1 <= (pix_valid && link_q == LINK_DUAL) ? px1 : RGB_BLACK;
    end
  end

  assign pix.hs      = hs;
  assign pix.vs      = vs;
  assign pix.de      = de;
  assign pix.data0_r = d0.r;
  assign pix.data0_g = d0.g;
  assign pix.data0_b = d0.b;
  assign pix.data1_r = d1.r;
  assign pix.data1_g = d1.g;
  assign pix.data1_b = d1.b;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen on a tiny raster; every output cycle is compared with a frame model
// computed from the raster and pattern rules.
module tb_video_pattern_gen;

  localparam int HA = 16, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4,  VF = 1, VS = 1, VB = 1;
  localparam int V_LINES = VS + VB + VA + VF;

  logic        pclk = 1'b0;
  logic        rst, en, link;
  logic [1:0]  pat;
  logic        sof;
  logic [15:0] fc;

  video_pattern_gen_if pix ();

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .pclk_i(pclk), .rst_i(rst), .en_i(en), .link_i(link), .pattern_sel_i(pat),
    .pix(pix), .sof_o(sof), .frame_cnt_o(fc)
  );

  always #5 pclk = ~pclk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic        cur_link;
  logic [1:0]  cur_pat;
  logic [15:0] exp_fc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int line_len(input logic l);
    return HS + HB + (l ? HA / 2 : HA) + HF;
  endfunction

  function automatic logic [23:0] ref_pixel(input int x, input int y, input logic [1:0] p,
                                            input logic [15:0] f);
    case (p)
      2'd0:
        case (x / (HA / 8))
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      2'd1:    return {8'(x), 8'(y), 8'(x ^ y)};
      2'd2:    return (((x / 16) + (y / 16)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
      default: return {f[7:0], f[7:0], f[7:0]};
    endcase
  endfunction

  function automatic logic [31:0] ctl_obs();
    return {28'd0, pix.hs, pix.vs, pix.de, sof};
  endfunction

  // Walks one frame, checking every output cycle; optionally stops early, changes
  // link/pattern, or drops en_i after the comparison at the given cycle.
  task automatic run_frame(input int stop_c, input int chg_c, input logic nl,
                           input logic [1:0] np, input int drop_c);
    int          a, lw, len, h, v, ax;
    logic        ede, l;
    logic [1:0]  p;
    logic [23:0] e0, e1;
    logic [15:0] efc;
    l   = cur_link;
    p   = cur_pat;
    a   = l ? HA / 2 : HA;
    lw  = line_len(l);
    len = lw * V_LINES;
    for (int c = 0; c < len; c++) begin
      @(negedge pclk);
      h   = c % lw;
      v   = c / lw;
      ede = (h >= HS + HB) && (h < HS + HB + a) && (v >= VS + VB) && (v < VS + VB + VA);
      ax  = h - (HS + HB);
      e0  = ede ? ref_pixel(l ? 2 * ax : ax, v - (VS + VB), p, exp_fc) : 24'h0;
      e1  = (ede && l) ? ref_pixel(2 * ax + 1, v - (VS + VB), p, exp_fc) : 24'h0;
      efc = (c == len - 1) ? exp_fc + 16'd1 : exp_fc;
      check($sformatf("ctl hs/vs/de/sof c%0d", c), ctl_obs(),
            {28'd0, h < HS, v < VS, ede, c == 0});
      check($sformatf("data0 c%0d", c), {8'd0, pix.data0_r, pix.data0_g, pix.data0_b}, {8'd0, e0});
      check($sformatf("data1 c%0d", c), {8'd0, pix.data1_r, pix.data1_g, pix.data1_b}, {8'd0, e1});
      check($sformatf("frame_cnt c%0d", c), {16'd0, fc}, {16'd0, efc});
      if (c == stop_c) return;
      if (c == chg_c) begin
        link = nl;
        pat  = np;
      end
      if (c == drop_c) en = 1'b0;
    end
    cur_link = link;
    cur_pat  = pat;
    exp_fc   = exp_fc + 16'd1;
  endtask

  task automatic idle_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge pclk);
      check({tag, " ctl"}, ctl_obs(), 32'd0);
      check({tag, " data"}, {8'd0, pix.data0_r | pix.data1_r, pix.data0_g | pix.data1_g,
                             pix.data0_b | pix.data1_b}, 32'd0);
      check({tag, " frame_cnt"}, {16'd0, fc}, {16'd0, exp_fc});
    end
  endtask

  function automatic int rand_chg(input logic l);
    return int'($urandom_range(1, line_len(l) * V_LINES - 3));
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; link = 1'b0; pat = 2'd0;
    exp_fc = '0; cur_link = 1'b0; cur_pat = 2'd0;

    idle_check(3, "reset");
    rst = 1'b0;
    idle_check(4, "idle");

    // Single-mode colour bars; mid-frame switch to dual gradient.
    en = 1'b1;
    run_frame(-1, rand_chg(cur_link), 1'b1, 2'd1, -1);
    // Dual gradient; mid-frame switch to single checkerboard.
    run_frame(-1, rand_chg(cur_link), 1'b0, 2'd2, -1);
    // Single checkerboard, then random link/pattern sequences.
    run_frame(-1, rand_chg(cur_link), 1'($urandom_range(0, 1)), 2'd3, -1);
    for (int f = 0; f < 4; f++)
      run_frame(-1, rand_chg(cur_link), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), -1);

    // Drop enable on line 3: the frame still completes, then the source idles.
    run_frame(-1, -1, 1'b0, 2'd0, 3 * line_len(cur_link) + 5);
    idle_check(10, "after-drop");

    // Preload the frame counter to its wrap point while idle.
    @(negedge pclk);
    force dut.u_core.frame_cnt_o = 16'hFFFF;
    #1;
    release dut.u_core.frame_cnt_o;
    exp_fc = 16'hFFFF;
    idle_check(2, "preload");

    // Re-enable: sof on the next output cycle; solid frame wraps the counter to 0.
    link = 1'($urandom_range(0, 1));
    pat  = 2'd3;
    cur_link = link;
    cur_pat  = pat;
    en = 1'b1;
    run_frame(-1, -1, 1'b0, 2'd0, -1);

    // Reset in the middle of an active line.
    run_frame(3 * line_len(cur_link) + 8, -1, 1'b0, 2'd0, -1);
    rst = 1'b1;
    #1;
    check("async rst ctl", ctl_obs(), 32'd0);
    check("async rst data0", {8'd0, pix.data0_r, pix.data0_g, pix.data0_b}, 32'd0);
    check("async rst frame_cnt", {16'd0, fc}, 32'd0);
    exp_fc = '0;
    @(negedge pclk);
    rst = 1'b0;
    cur_link = link;
    cur_pat  = pat;
    run_frame(-1, -1, 1'b0, 2'd0, 2 * line_len(cur_link) + 3);
    idle_check(5, "final idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
